// File: rtl/rgb_pwm.sv
// rtl/rgb_pwm.sv - per-channel 8-bit PWM LED driver with double-buffered duty load
module rgb_pwm #(
   parameter int unsigned PRESCALE = 1,
   parameter bit          INVERT   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] duty_r,
   input  logic [7:0] duty_g,
   input  logic [7:0] duty_b,
   input  logic       load,
   output logic       ready,
   output logic       period_start,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b
);

   // Prescaler width never drops below one bit so PRESCALE=1 still elaborates.
   localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_cnt_q, pre_cnt_d;
   logic [7:0]    pwm_cnt_q, pwm_cnt_d;
   logic [7:0]    shd_r_q, shd_r_d;
   logic [7:0]    shd_g_q, shd_g_d;
   logic [7:0]    shd_b_q, shd_b_d;
   logic [7:0]    act_r_q, act_r_d;
   logic [7:0]    act_g_q, act_g_d;
   logic [7:0]    act_b_q, act_b_d;
   logic          pending_q, pending_d;
   logic          period_start_q, period_start_d;
   logic [2:0]    led_q, led_d;

   logic          tick;
   logic          boundary;
   logic          accept;

   assign tick     = (pre_cnt_q == PRE_LAST);
   assign boundary = tick && (pwm_cnt_q == 8'hFF);
   assign ready    = !pending_q;
   assign accept   = load && ready;

   // Next state: counters advance, loads fill the shadow bank, boundaries promote it.
   always_comb begin
      pre_cnt_d      = pre_cnt_q;
      pwm_cnt_d      = pwm_cnt_q;
      shd_r_d        = shd_r_q;
      shd_g_d        = shd_g_q;
      shd_b_d        = shd_b_q;
      act_r_d        = act_r_q;
      act_g_d        = act_g_q;
      act_b_d        = act_b_q;
      pending_d      = pending_q;
      period_start_d = boundary;
      led_d          = {(pwm_cnt_q < act_b_q),
                        (pwm_cnt_q < act_g_q),
                        (pwm_cnt_q < act_r_q)} ^ {3{INVERT}};

      if (tick) begin
         pre_cnt_d = '0;
         pwm_cnt_d = pwm_cnt_q + 8'd1;
      end else begin
         pre_cnt_d = pre_cnt_q + PW'(1);
      end

      // Accept only happens with pending clear, so it never collides with the
      // promotion below; a load on the boundary cycle waits for the next one.
      if (accept) begin
         shd_r_d   = duty_r;
         shd_g_d   = duty_g;
         shd_b_d   = duty_b;
         pending_d = 1'b1;
      end

      if (boundary && pending_q) begin
         act_r_d   = shd_r_q;
         act_g_d   = shd_g_q;
         act_b_d   = shd_b_q;
         pending_d = 1'b0;
      end
   end

   // State register; reset parks everything with the LEDs off.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q      <= '0;
         pwm_cnt_q      <= '0;
         shd_r_q        <= '0;
         shd_g_q        <= '0;
         shd_b_q        <= '0;
         act_r_q        <= '0;
         act_g_q        <= '0;
         act_b_q        <= '0;
         pending_q      <= 1'b0;
         period_start_q <= 1'b0;
         led_q          <= {3{INVERT}};
      end else begin
         pre_cnt_q      <= pre_cnt_d;
         pwm_cnt_q      <= pwm_cnt_d;
         shd_r_q        <= shd_r_d;
         shd_g_q        <= shd_g_d;
         shd_b_q        <= shd_b_d;
         act_r_q        <= act_r_d;
         act_g_q        <= act_g_d;
         act_b_q        <= act_b_d;
         pending_q      <= pending_d;
         period_start_q <= period_start_d;
         led_q          <= led_d;
      end
   end

   assign period_start = period_start_q;
   assign led_r        = led_q[0];
   assign led_g        = led_q[1];
   assign led_b        = led_q[2];

endmodule

// File: tb/tb_rgb_pwm.sv
// tb/tb_rgb_pwm.sv - randomized and directed bench for rgb_pwm against a time-based model
module tb_rgb_pwm;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [7:0] duty_r, duty_g, duty_b;

   logic [1:0]      ready_v;
   logic [1:0]      ps_v;
   logic [1:0][2:0] led_v;

   always #5 clk = ~clk;

   rgb_pwm #(.PRESCALE(1), .INVERT(1'b0)) u_dut0 (
      .clk          (clk),
      .rst          (rst),
      .duty_r       (duty_r),
      .duty_g       (duty_g),
      .duty_b       (duty_b),
      .load         (load),
      .ready        (ready_v[0]),
      .period_start (ps_v[0]),
      .led_r        (led_v[0][0]),
      .led_g        (led_v[0][1]),
      .led_b        (led_v[0][2])
   );

   rgb_pwm #(.PRESCALE(4), .INVERT(1'b1)) u_dut1 (
      .clk          (clk),
      .rst          (rst),
      .duty_r       (duty_r),
      .duty_g       (duty_g),
      .duty_b       (duty_b),
      .load         (load),
      .ready        (ready_v[1]),
      .period_start (ps_v[1]),
      .led_r        (led_v[1][0]),
      .led_g        (led_v[1][1]),
      .led_b        (led_v[1][2])
   );

   int checks = 0;
   int errors = 0;

   // Model: time since reset, active duties, and one pending load with its apply time.
   int unsigned m_t     [2];
   logic [7:0]  m_act   [2][3];
   logic [7:0]  m_shd   [2][3];
   bit          m_pend  [2];
   int unsigned m_apply [2];
   logic        m_led   [2][3];

   int   hi_cnt [2][3];
   int   edges_g0;
   logic prev_g0;

   function automatic int unsigned ps_of(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   function automatic logic inv_of(input int d);
      return (d == 0) ? 1'b0 : 1'b1;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_cnt();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 3; c++)
            hi_cnt[d][c] = 0;
      edges_g0 = 0;
   endtask

   // One clock: drive inputs, advance the model across the edge, check all outputs.
   task automatic step(input bit r, input bit ld, input logic [7:0] dr, input logic [7:0] dg,
                       input logic [7:0] db);
      logic [7:0]  dv [3];
      int unsigned per;
      int unsigned cnt;
      dv[0] = dr; dv[1] = dg; dv[2] = db;
      rst = r; load = ld; duty_r = dr; duty_g = dg; duty_b = db;
      for (int d = 0; d < 2; d++) begin
         per = 256 * ps_of(d);
         if (r) begin
            m_t[d]    = 0;
            m_pend[d] = 1'b0;
            for (int c = 0; c < 3; c++) begin
               m_act[d][c] = 8'd0;
               m_shd[d][c] = 8'd0;
               m_led[d][c] = inv_of(d);
            end
         end else begin
            cnt = (m_t[d] / ps_of(d)) % 256;
            for (int c = 0; c < 3; c++)
               m_led[d][c] = ((cnt < 32'(m_act[d][c])) ? 1'b1 : 1'b0) ^ inv_of(d);
            if (ld && !m_pend[d]) begin
               for (int c = 0; c < 3; c++) m_shd[d][c] = dv[c];
               m_pend[d]  = 1'b1;
               m_apply[d] = ((m_t[d] + 1) / per + 1) * per;
            end
            m_t[d]++;
            if (m_pend[d] && m_t[d] == m_apply[d]) begin
               for (int c = 0; c < 3; c++) m_act[d][c] = m_shd[d][c];
               m_pend[d] = 1'b0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         per = 256 * ps_of(d);
         check_val($sformatf("d%0d ready t=%0d", d, m_t[d]), 32'(ready_v[d]), 32'(!m_pend[d]));
         check_val($sformatf("d%0d period_start t=%0d", d, m_t[d]), 32'(ps_v[d]),
                   32'((m_t[d] != 0) && (m_t[d] % per == 0)));
         for (int c = 0; c < 3; c++) begin
            check_val($sformatf("d%0d led%0d t=%0d", d, c, m_t[d]), 32'(led_v[d][c]),
                      32'(m_led[d][c]));
            if (led_v[d][c] !== inv_of(d)) hi_cnt[d][c]++;
         end
      end
      if (led_v[0][1] !== prev_g0) edges_g0++;
      prev_g0 = led_v[0][1];
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
   endtask

   // Step until the given DUT pulses period_start, bounded by a cycle budget.
   task automatic run_to_ps(input int d, input int bound, output int n);
      n = 0;
      do begin
         step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
         n++;
      end while (ps_v[d] !== 1'b1 && n < bound);
      check_val($sformatf("d%0d period_start seen", d), 32'(ps_v[d]), 32'd1);
   endtask

   int n;

   initial begin
      rst = 1'b1; load = 1'b0; duty_r = '0; duty_g = '0; duty_b = '0;
      prev_g0 = 1'b0;
      clear_cnt();

      // Reset state
      repeat (3) step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      check_val("rst ready", 32'(ready_v), 32'h3);
      check_val("rst led0", 32'(led_v[0]), 32'h0);
      check_val("rst led1", 32'(led_v[1]), 32'h7);
      check_val("rst period_start", 32'(ps_v), 32'h0);

      // Duty levels, loaded on the first cycle out of reset
      step(1'b0, 1'b1, 8'd0, 8'd128, 8'd255);
      run_to_ps(0, 300, n);
      check_val("first ps gap", 32'(n + 1), 32'd256);
      clear_cnt();
      idle(256);
      check_val("levels r", 32'(hi_cnt[0][0]), 32'd0);
      check_val("levels g", 32'(hi_cnt[0][1]), 32'd128);
      check_val("levels b", 32'(hi_cnt[0][2]), 32'd255);
      check_val("levels g edges", 32'(edges_g0), 32'd2);
      check_val("ps spacing d0", 32'(ps_v[0]), 32'd1);

      // Handshake: load at pwm_cnt=10, second load ignored while busy
      idle(10);
      step(1'b0, 1'b1, 8'h40, 8'h40, 8'h40);
      check_val("hs ready low", 32'(ready_v[0]), 32'd0);
      step(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
      run_to_ps(0, 300, n);
      check_val("hs ready after apply", 32'(ready_v[0]), 32'd1);
      clear_cnt();
      idle(256);
      check_val("hs r", 32'(hi_cnt[0][0]), 32'd64);
      check_val("hs b", 32'(hi_cnt[0][2]), 32'd64);

      // Mid-period update: g=200 active, load g=20 at pwm_cnt=100
      step(1'b0, 1'b1, 8'd0, 8'd200, 8'd0);
      run_to_ps(0, 300, n);
      clear_cnt();
      idle(100);
      step(1'b0, 1'b1, 8'd0, 8'd20, 8'd0);
      idle(155);
      check_val("mid cur g", 32'(hi_cnt[0][1]), 32'd200);
      check_val("mid cur edges", 32'(edges_g0), 32'd2);
      clear_cnt();
      idle(256);
      check_val("mid next g", 32'(hi_cnt[0][1]), 32'd20);
      check_val("mid next edges", 32'(edges_g0), 32'd2);

      // Reset mid-operation with a pending 255 load
      step(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
      idle(76);
      step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      check_val("midrst ready", 32'(ready_v), 32'h3);
      check_val("midrst led0", 32'(led_v[0]), 32'h0);
      check_val("midrst led1", 32'(led_v[1]), 32'h7);
      clear_cnt();
      idle(600);
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 3; c++)
            check_val($sformatf("midrst d%0d ch%0d stays off", d, c), 32'(hi_cnt[d][c]), 32'd0);

      // Prescale 4 with inverted pins
      step(1'b0, 1'b1, 8'd3, 8'd0, 8'd0);
      run_to_ps(1, 1100, n);
      clear_cnt();
      run_to_ps(1, 1100, n);
      check_val("ps spacing d1", 32'(n), 32'd1024);
      check_val("d1 r active cycles", 32'(hi_cnt[1][0]), 32'd12);
      check_val("d1 g active cycles", 32'(hi_cnt[1][1]), 32'd0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 5000; i++) begin
         step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 7) == 0),
              8'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
